// File: rtl/mcbsp_pkg.sv
// Shared types and widths for the McBSP transmit feeder.
// State encoding is fixed so that traces and older tooling see stable values.
package mcbsp_pkg;

    localparam int MCBSP_BYTE_W = 8;
    localparam int MCBSP_NUM_W  = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SEND  = 2'd2,
        TAIL  = 2'd3
    } mcbsp_state_e;

endpackage

// File: rtl/mcbsp_pingpong_ram.sv
// Two-bank frame buffer: one write port, one registered read port.
// The top bit of each address selects the bank.
module mcbsp_pingpong_ram #(
    parameter int DATA_W  = 8,
    parameter int DEPTH_W = 9
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [DEPTH_W:0]   waddr_i,
    input  logic [DATA_W-1:0]  wdata_i,
    input  logic [DEPTH_W:0]   raddr_i,
    output logic [DATA_W-1:0]  rdata_o
);

    logic [DATA_W-1:0] mem_q [0:(2**(DEPTH_W+1))-1];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mcbsp_tx_feeder.sv
// Buffers producer frames in a ping-pong RAM and feeds them byte-by-byte to the McBSP master.
// Write control, bank flags and the read FSM live here; storage is in mcbsp_pingpong_ram.
module mcbsp_tx_feeder
    import mcbsp_pkg::*;
#(
    parameter int DATA_W    = MCBSP_BYTE_W,
    parameter int MAX_FRAME = 511,
    parameter int TAIL_PAD  = 8
) (
    input  logic                    mcbsp_clk_in,
    input  logic                    mcbsp_rst_n_in,
    input  logic [6:0]              cfg_reg_length,
    input  logic                    wr_valid,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    wr_last,
    output logic                    wr_ready,
    input  logic                    mcbsp_update_in,
    output logic                    mcbsp_master_en,
    output logic [MCBSP_NUM_W-1:0]  mcbsp_reg_number,
    output logic [DATA_W-1:0]       mcbsp_data_out,
    output logic                    frame_done,
    output logic                    underrun
);

    localparam int NW = MCBSP_NUM_W;

    logic                     wr_bank_q, wr_bank_d;
    logic [NW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [1:0]               bank_full_q, bank_full_d;
    logic [1:0][NW-1:0]       bank_len_q, bank_len_d;
    logic                     rd_bank_q, rd_bank_d;
    logic [NW-1:0]            rd_cnt_q, rd_cnt_d;
    logic [NW-1:0]            tail_cnt_q, tail_cnt_d;
    logic [NW-1:0]            reg_number_q, reg_number_d;
    logic [DATA_W-1:0]        data_out_q, data_out_d;
    logic                     frame_done_q, frame_done_d;
    logic                     underrun_q, underrun_d;
    mcbsp_state_e             state_q, state_d;

    logic                     wr_accept;
    logic                     wr_close;
    logic [DATA_W-1:0]        ram_rdata;

    assign wr_ready  = !bank_full_q[wr_bank_q];
    assign wr_accept = wr_valid && wr_ready;
    assign wr_close  = wr_accept && (wr_last || (wr_ptr_q == NW'(MAX_FRAME - 1)));

    // Read address follows the next-state pointer so the RAM output already holds
    // the upcoming byte when the next update arrives, even on back-to-back updates.
    mcbsp_pingpong_ram #(
        .DATA_W  (DATA_W),
        .DEPTH_W (NW)
    ) u_ram (
        .clk_i   (mcbsp_clk_in),
        .we_i    (wr_accept),
        .waddr_i ({wr_bank_q, wr_ptr_q}),
        .wdata_i (wr_data),
        .raddr_i ({rd_bank_d, rd_cnt_d}),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        wr_bank_d    = wr_bank_q;
        wr_ptr_d     = wr_ptr_q;
        bank_full_d  = bank_full_q;
        bank_len_d   = bank_len_q;
        rd_bank_d    = rd_bank_q;
        rd_cnt_d     = rd_cnt_q;
        tail_cnt_d   = tail_cnt_q;
        reg_number_d = reg_number_q;
        data_out_d   = data_out_q;
        frame_done_d = 1'b0;
        underrun_d   = underrun_q;
        state_d      = state_q;

        if (wr_accept) begin
            if (wr_close) begin
                bank_len_d[wr_bank_q]  = wr_ptr_q + NW'(1);
                bank_full_d[wr_bank_q] = 1'b1;
                wr_bank_d              = !wr_bank_q;
                wr_ptr_d               = '0;
            end else begin
                wr_ptr_d = wr_ptr_q + NW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (bank_full_q[rd_bank_q]) begin
                    reg_number_d = bank_len_q[rd_bank_q];
                    rd_cnt_d     = '0;
                    state_d      = START;
                end
            end
            START: state_d = SEND;
            SEND: begin
                if (mcbsp_update_in) begin
                    data_out_d = ram_rdata;
                    rd_cnt_d   = rd_cnt_q + NW'(1);
                    if ((rd_cnt_q + NW'(1)) == reg_number_q) begin
                        tail_cnt_d = NW'({cfg_reg_length, 1'b0}) + NW'(TAIL_PAD);
                        state_d    = TAIL;
                    end
                end
            end
            TAIL: begin
                // Hold off the next start until the master has shifted its trailing slots.
                if (tail_cnt_q <= NW'(1)) begin
                    tail_cnt_d             = '0;
                    bank_full_d[rd_bank_q] = 1'b0;
                    rd_bank_d              = !rd_bank_q;
                    frame_done_d           = 1'b1;
                    state_d                = IDLE;
                end else begin
                    tail_cnt_d = tail_cnt_q - NW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (mcbsp_update_in && (state_q != SEND)) begin
            underrun_d = 1'b1;
            data_out_d = '0;
        end
    end

    always_ff @(posedge mcbsp_clk_in or negedge mcbsp_rst_n_in) begin
        if (!mcbsp_rst_n_in) begin
            wr_bank_q    <= 1'b0;
            wr_ptr_q     <= '0;
            bank_full_q  <= '0;
            bank_len_q   <= '0;
            rd_bank_q    <= 1'b0;
            rd_cnt_q     <= '0;
            tail_cnt_q   <= '0;
            reg_number_q <= '0;
            data_out_q   <= '0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
            state_q      <= IDLE;
        end else begin
            wr_bank_q    <= wr_bank_d;
            wr_ptr_q     <= wr_ptr_d;
            bank_full_q  <= bank_full_d;
            bank_len_q   <= bank_len_d;
            rd_bank_q    <= rd_bank_d;
            rd_cnt_q     <= rd_cnt_d;
            tail_cnt_q   <= tail_cnt_d;
            reg_number_q <= reg_number_d;
            data_out_q   <= data_out_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
            state_q      <= state_d;
        end
    end

    assign mcbsp_master_en  = (state_q == START);
    assign mcbsp_reg_number = reg_number_q;
    assign mcbsp_data_out   = data_out_q;
    assign frame_done       = frame_done_q;
    assign underrun         = underrun_q;

endmodule

// File: tb/tb_mcbsp_tx_feeder.sv
// Directed bench for mcbsp_tx_feeder: short frame, max-length frame, back-pressure,
// underrun and mid-frame reset, with expected values written out by hand.
module tb_mcbsp_tx_feeder;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic [6:0]  cfg      = 7'd8;
    logic        wr_valid = 1'b0;
    logic [7:0]  wr_data  = 8'h00;
    logic        wr_last  = 1'b0;
    logic        wr_ready;
    logic        upd      = 1'b0;
    logic        men;
    logic [8:0]  regn;
    logic [7:0]  dout;
    logic        fd;
    logic        und;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [7:0] fbuf [0:511];

    mcbsp_tx_feeder dut (
        .mcbsp_clk_in     (clk),
        .mcbsp_rst_n_in   (rst_n),
        .cfg_reg_length   (cfg),
        .wr_valid         (wr_valid),
        .wr_data          (wr_data),
        .wr_last          (wr_last),
        .wr_ready         (wr_ready),
        .mcbsp_update_in  (upd),
        .mcbsp_master_en  (men),
        .mcbsp_reg_number (regn),
        .mcbsp_data_out   (dout),
        .frame_done       (fd),
        .underrun         (und)
    );

    always #25 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic l);
        int t = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = l;
        while (!wr_ready && t < 3000) begin
            tick();
            t++;
        end
        check_eq("push_ready", {31'b0, wr_ready}, 1);
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic update(input logic [7:0] exp, input string tag);
        upd = 1'b1;
        tick();
        upd = 1'b0;
        check_eq(tag, {24'b0, dout}, {24'b0, exp});
    endtask

    task automatic wait_men(input string tag);
        int t = 0;
        while (men !== 1'b1 && t < 3000) begin
            tick();
            t++;
        end
        check_eq(tag, {31'b0, men}, 1);
    endtask

    task automatic wait_fd(input string tag);
        int t = 0;
        while (fd !== 1'b1 && t < 3000) begin
            tick();
            t++;
        end
        check_eq(tag, {31'b0, fd}, 1);
    endtask

    task automatic send_frame(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            update(fbuf[i], tag);
            tick();
        end
    endtask

    initial begin
        int e0;
        int bad;
        int t;

        // Reset state
        #5 rst_n = 1'b0;
        repeat (3) tick();
        check_eq("rst_wr_ready", {31'b0, wr_ready}, 1);
        check_eq("rst_master_en", {31'b0, men}, 0);
        check_eq("rst_reg_number", {23'b0, regn}, 0);
        check_eq("rst_data_out", {24'b0, dout}, 0);
        check_eq("rst_frame_done", {31'b0, fd}, 0);
        check_eq("rst_underrun", {31'b0, und}, 0);
        rst_n = 1'b1;
        tick();

        // Three-byte frame, cfg_reg_length = 8
        push(8'hA1, 1'b0);
        push(8'hB2, 1'b0);
        push(8'hC3, 1'b1);
        wait_men("t1_master_en");
        check_eq("t1_reg_number", {23'b0, regn}, 3);
        tick();
        check_eq("t1_master_en_single", {31'b0, men}, 0);
        update(8'hA1, "t1_byte0");
        tick();
        update(8'hB2, "t1_byte1");
        tick();
        update(8'hC3, "t1_byte2");
        e0 = cyc;
        wait_fd("t1_frame_done");
        check_eq("t1_done_delay", cyc - e0, 24);
        tick();
        check_eq("t1_done_pulse", {31'b0, fd}, 0);
        check_eq("t1_no_underrun", {31'b0, und}, 0);

        // Update with nothing buffered
        update(8'h00, "t2_underrun_data");
        check_eq("t2_underrun_set", {31'b0, und}, 1);
        tick();

        // Max-length frame closes itself at 511 bytes
        for (int i = 0; i < 511; i++) fbuf[i] = 8'((i * 37 + 5) & 8'hFF);
        for (int i = 0; i < 511; i++) push(fbuf[i], 1'b0);
        wait_men("t3_master_en");
        check_eq("t3_reg_number", {23'b0, regn}, 511);
        tick();
        send_frame(511, "t3_byte");
        wait_fd("t3_frame_done");
        check_eq("t3_underrun_sticky", {31'b0, und}, 1);
        tick();

        // Back-to-back frames fill both banks
        fbuf[0] = 8'h11; fbuf[1] = 8'h22; fbuf[2] = 8'h33; fbuf[3] = 8'h44;
        for (int i = 0; i < 4; i++) push(fbuf[i], i == 3);
        push(8'h55, 1'b0);
        push(8'h66, 1'b0);
        push(8'h77, 1'b0);
        push(8'h88, 1'b1);
        check_eq("t4_both_full_ready", {31'b0, wr_ready}, 0);
        check_eq("t4_f1_reg_number", {23'b0, regn}, 4);
        send_frame(4, "t4_f1_byte");
        bad = 0;
        t = 0;
        while (fd !== 1'b1 && t < 3000) begin
            if (wr_ready) bad++;
            tick();
            t++;
        end
        check_eq("t4_ready_held_low", bad, 0);
        check_eq("t4_f1_frame_done", {31'b0, fd}, 1);
        check_eq("t4_ready_after_done", {31'b0, wr_ready}, 1);
        tick();
        check_eq("t4_f2_master_en", {31'b0, men}, 1);
        check_eq("t4_f2_reg_number", {23'b0, regn}, 4);
        tick();
        check_eq("t4_f2_master_en_single", {31'b0, men}, 0);
        push(8'h99, 1'b0);
        push(8'hAA, 1'b0);
        push(8'hBB, 1'b0);
        push(8'hCC, 1'b1);
        fbuf[0] = 8'h55; fbuf[1] = 8'h66; fbuf[2] = 8'h77; fbuf[3] = 8'h88;
        send_frame(4, "t4_f2_byte");
        wait_fd("t4_f2_frame_done");
        tick();
        check_eq("t4_f3_master_en", {31'b0, men}, 1);
        tick();
        fbuf[0] = 8'h99; fbuf[1] = 8'hAA; fbuf[2] = 8'hBB; fbuf[3] = 8'hCC;
        send_frame(4, "t4_f3_byte");
        wait_fd("t4_f3_frame_done");
        tick();

        // Reset in the middle of a five-byte frame
        for (int i = 0; i < 5; i++) push(8'(i + 1), i == 4);
        wait_men("t5_master_en");
        tick();
        update(8'h01, "t5_byte0");
        tick();
        update(8'h02, "t5_byte1");
        #10 rst_n = 1'b0;
        #1;
        check_eq("t5_rst_data_out", {24'b0, dout}, 0);
        check_eq("t5_rst_reg_number", {23'b0, regn}, 0);
        check_eq("t5_rst_master_en", {31'b0, men}, 0);
        check_eq("t5_rst_wr_ready", {31'b0, wr_ready}, 1);
        check_eq("t5_rst_frame_done", {31'b0, fd}, 0);
        check_eq("t5_rst_underrun", {31'b0, und}, 0);
        #10 rst_n = 1'b1;
        tick();
        push(8'h5A, 1'b0);
        push(8'hA5, 1'b1);
        wait_men("t5_next_master_en");
        check_eq("t5_next_reg_number", {23'b0, regn}, 2);
        tick();
        update(8'h5A, "t5_next_byte0");
        tick();
        update(8'hA5, "t5_next_byte1");
        wait_fd("t5_next_frame_done");
        check_eq("t5_next_no_underrun", {31'b0, und}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
